// File: rtl/sli_pkg.sv
// Shared constants for the SLI LUT loader: table geometry, error codes, FSM encoding.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package sli_pkg;

  // One full SLI index space per table.
  localparam int          SLI_LUT_DEPTH = 720;
  localparam int          SLI_AW        = 10;
  localparam logic [19:0] SLI_TIMEOUT   = 20'hFFFFF;

  // Load error codes shown on the debug display.
  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_OVERFLOW = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b10;
  localparam logic [1:0] ERR_UNDERRUN = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_FULL = 2'b10,
    ST_ERR  = 2'b11
  } sli_state_e;

endpackage

// File: rtl/sli_lut_bank_ram.sv
// Two LUT banks in one simple dual-port RAM (bank 1 sits above bank 0), registered read.
// Latency: read data valid one cycle after re/raddr; writes land on the same edge.
// Backpressure: none; caller never writes the bank it reads, so there is no collision.
module sli_lut_bank_ram #(
  parameter int DEPTH = 720,
  parameter int AW    = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic          wbank,
  input  logic [AW-1:0] waddr,
  input  logic [7:0]    wdata,
  input  logic          re,
  input  logic          rbank,
  input  logic [AW-1:0] raddr,
  output logic [7:0]    rdata
);

  localparam int IW = AW + 1;

  logic [7:0]    mem [2*DEPTH];
  logic [IW-1:0] widx;
  logic [IW-1:0] ridx;
  logic [7:0]    rdata_q;

  // Linear index: bank 1 is offset by one table so the array is exactly two tables deep.
  always_comb begin
    widx = wbank ? (IW'(DEPTH) + {1'b0, waddr}) : {1'b0, waddr};
    ridx = rbank ? (IW'(DEPTH) + {1'b0, raddr}) : {1'b0, raddr};
  end

  // Write port; contents are deliberately not reset so this maps onto block RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[widx] <= wdata;
    end
  end

  // Registered read; re is only raised for in-range addresses.
  always_ff @(posedge clk) begin
    if (re) begin
      rdata_q <= mem[ridx];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/sli_lut_loader.sv
// Fills the inactive bank of a ping-pong intensity LUT from the SD byte stream and swaps it in at a frame boundary.
// Latency: rd_data one cycle after rd_addr; a completed table goes live on the first frame_start after completion.
// Backpressure: none; the byte stream cannot be stalled, so excess bytes are dropped and flagged, stalls time out.
module sli_lut_loader
  import sli_pkg::*;
#(
  parameter int          LUT_DEPTH = SLI_LUT_DEPTH,
  parameter int          AW        = SLI_AW,
  parameter logic [19:0] TIMEOUT   = SLI_TIMEOUT
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          load_start,
  input  logic          in_valid,
  input  logic [7:0]    in_byte,
  input  logic          frame_start,
  input  logic [AW-1:0] rd_addr,
  output logic [7:0]    rd_data,
  output logic          lut_valid,
  output logic          loading,
  output logic          swap_pending,
  output logic [1:0]    err,
  output logic [7:0]    lut_sum
);

  localparam logic [AW-1:0] LAST_ADDR = AW'(LUT_DEPTH - 1);

  sli_state_e    state_q, state_d;
  logic          bank_q, bank_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [7:0]    wsum_q, wsum_d;
  logic [19:0]   timer_q, timer_d;
  logic [1:0]    err_q, err_d;
  logic          swap_pending_q, swap_pending_d;
  logic          lut_valid_q, lut_valid_d;
  logic [7:0]    lut_sum_q, lut_sum_d;
  logic          rd_ok_q;
  logic          we;
  logic          rd_in_range;
  logic [7:0]    ram_rdata;

  assign rd_in_range = (rd_addr <= LAST_ADDR);

  // Next-state logic: load sequencing, error capture and the frame-aligned bank swap.
  always_comb begin
    state_d        = state_q;
    bank_d         = bank_q;
    wptr_d         = wptr_q;
    wsum_d         = wsum_q;
    timer_d        = timer_q;
    err_d          = err_q;
    swap_pending_d = swap_pending_q;
    lut_valid_d    = lut_valid_q;
    lut_sum_d      = lut_sum_q;
    we             = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (load_start) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
          wsum_d  = '0;
          timer_d = '0;
          err_d   = ERR_NONE;
        end
      end

      ST_LOAD: begin
        if (load_start) begin
          // Restart from scratch; any byte arriving with the restart pulse is dropped.
          err_d   = ERR_UNDERRUN;
          wptr_d  = '0;
          wsum_d  = '0;
          timer_d = '0;
        end else if (in_valid) begin
          we      = 1'b1;
          wsum_d  = wsum_q + in_byte;
          timer_d = '0;
          if (wptr_q == LAST_ADDR) begin
            state_d        = ST_FULL;
            swap_pending_d = 1'b1;
          end else begin
            wptr_d = wptr_q + AW'(1);
          end
        end else if (timer_q == TIMEOUT - 20'd1) begin
          state_d = ST_ERR;
          err_d   = ERR_TIMEOUT;
        end else begin
          timer_d = timer_q + 20'd1;
        end
      end

      ST_FULL: begin
        // The table is complete; surplus bytes are discarded but the swap still goes ahead.
        if (in_valid) begin
          err_d = ERR_OVERFLOW;
        end
        // swap_pending_q is registered, so a final byte coinciding with frame_start waits a frame.
        if (frame_start && swap_pending_q) begin
          bank_d         = ~bank_q;
          lut_valid_d    = 1'b1;
          lut_sum_d      = wsum_q;
          swap_pending_d = 1'b0;
          state_d        = ST_IDLE;
        end
      end

      ST_ERR: begin
        swap_pending_d = 1'b0;
        if (load_start) begin
          state_d = ST_LOAD;
          wptr_d  = '0;
          wsum_d  = '0;
          timer_d = '0;
          err_d   = ERR_NONE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Control state registers; async clear drops lut_valid so the generator falls back to pass-through.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= ST_IDLE;
      bank_q         <= 1'b0;
      wptr_q         <= '0;
      wsum_q         <= '0;
      timer_q        <= '0;
      err_q          <= ERR_NONE;
      swap_pending_q <= 1'b0;
      lut_valid_q    <= 1'b0;
      lut_sum_q      <= '0;
    end else begin
      state_q        <= state_d;
      bank_q         <= bank_d;
      wptr_q         <= wptr_d;
      wsum_q         <= wsum_d;
      timer_q        <= timer_d;
      err_q          <= err_d;
      swap_pending_q <= swap_pending_d;
      lut_valid_q    <= lut_valid_d;
      lut_sum_q      <= lut_sum_d;
    end
  end

  // Read qualifier tracks the RAM pipeline: out-of-range or no-table lookups return zero.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_ok_q <= 1'b0;
    end else begin
      rd_ok_q <= rd_in_range && lut_valid_q;
    end
  end

  // Writes always target the inactive bank; reads use the bank active in the sampling cycle.
  sli_lut_bank_ram #(
    .DEPTH (LUT_DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (we),
    .wbank (~bank_q),
    .waddr (wptr_q),
    .wdata (in_byte),
    .re    (rd_in_range),
    .rbank (bank_q),
    .raddr (rd_addr),
    .rdata (ram_rdata)
  );

  assign rd_data      = rd_ok_q ? ram_rdata : 8'h00;
  assign lut_valid    = lut_valid_q;
  assign loading      = (state_q == ST_LOAD);
  assign swap_pending = swap_pending_q;
  assign err          = err_q;
  assign lut_sum      = lut_sum_q;

endmodule
